// File: rtl/ram_image_port_if.sv
// Host load stream, dump stream, CPU hold control and testbench RAM port of ram_image_port.
// master: the sequencer side. slave: the host, CPU and RAM side.
interface ram_image_port_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        halt;
  logic        cpu_run;
  logic        dp_valid;
  logic        dp_ready;
  logic [31:0] dp_addr;
  logic [31:0] dp_data;
  logic        dp_done;
  logic        err;
  logic        tbCTRL;
  logic        WEN;
  logic        REN;
  logic [31:0] addr;
  logic [31:0] store;
  logic [31:0] load;
  logic [1:0]  ramstate;

  modport master (
    input  ld_valid, ld_addr, ld_data, ld_last, halt, dp_ready, load, ramstate,
    output ld_ready, cpu_run, dp_valid, dp_addr, dp_data, dp_done, err,
           tbCTRL, WEN, REN, addr, store
  );

  modport slave (
    output ld_valid, ld_addr, ld_data, ld_last, halt, dp_ready, load, ramstate,
    input  ld_ready, cpu_run, dp_valid, dp_addr, dp_data, dp_done, err,
           tbCTRL, WEN, REN, addr, store
  );
endinterface

// File: rtl/ram_image_port.sv
// Sequencer on the testbench RAM port: loads a host program image while the
// CPU is held, releases the CPU until halt, then dumps a RAM window to the host.
module ram_image_port #(
  parameter logic [31:0] DUMP_BASE  = 32'h0,
  parameter int unsigned DUMP_WORDS = 1024,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic             CLK,
  input logic             nRST,
  ram_image_port_if.master bus
);

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {
    LOAD_IDLE, LOAD_WR, RUN, DUMP_RD, DUMP_OUT, DONE, FAULT
  } state_t;

  localparam logic [31:0] LAST_IDX = 32'(DUMP_WORDS - 1);
  localparam logic [16:0] TMO_LIM  = 17'(TIMEOUT);

  state_t      state, next_state;
  ramstate_t   rs;
  logic [31:0] addr_q, store_q, dp_addr_q, dp_data_q, idx_q;
  logic        last_q;
  logic [15:0] wcnt_q;
  logic [16:0] wcnt_inc;
  logic        tmo, last_word;
  logic        ld_ready_c, cpu_run_c, dp_valid_c, dp_done_c, err_c;
  logic        tbctrl_c, wen_c, ren_c;

  assign rs        = ramstate_t'(bus.ramstate);
  assign wcnt_inc  = {1'b0, wcnt_q} + 17'd1;
  // Fault on the wait cycle that would bring the count up to TIMEOUT.
  assign tmo       = (rs != ACCESS) && (wcnt_inc == TMO_LIM);
  assign last_word = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= LOAD_IDLE;
    else       state <= next_state;
  end

  // Next-state decode and state-derived port controls.
  always_comb begin
    next_state = state;
    ld_ready_c = 1'b0;
    cpu_run_c  = 1'b0;
    dp_valid_c = 1'b0;
    dp_done_c  = 1'b0;
    err_c      = 1'b0;
    tbctrl_c   = 1'b1;
    wen_c      = 1'b0;
    ren_c      = 1'b0;
    case (state)
      LOAD_IDLE: begin
        ld_ready_c = 1'b1;
        if (bus.ld_valid) next_state = LOAD_WR;
      end
      LOAD_WR: begin
        wen_c = 1'b1;
        if (rs == ERROR || tmo) next_state = FAULT;
        else if (rs == ACCESS)  next_state = last_q ? RUN : LOAD_IDLE;
      end
      RUN: begin
        tbctrl_c  = 1'b0;
        cpu_run_c = 1'b1;
        if (bus.halt) next_state = DUMP_RD;
      end
      DUMP_RD: begin
        cpu_run_c = 1'b1;
        ren_c     = 1'b1;
        if (rs == ERROR || tmo) next_state = FAULT;
        else if (rs == ACCESS)  next_state = DUMP_OUT;
      end
      DUMP_OUT: begin
        cpu_run_c  = 1'b1;
        dp_valid_c = 1'b1;
        if (bus.dp_ready) next_state = last_word ? DONE : DUMP_RD;
      end
      DONE: begin
        cpu_run_c = 1'b1;
        dp_done_c = 1'b1;
      end
      FAULT: begin
        err_c = 1'b1;
      end
      default: next_state = FAULT;
    endcase
  end

  // Address/data capture, dump index and RAM wait counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q    <= '0;
      store_q   <= '0;
      last_q    <= 1'b0;
      dp_addr_q <= '0;
      dp_data_q <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
    end else begin
      case (state)
        LOAD_IDLE: if (bus.ld_valid) begin
          addr_q  <= bus.ld_addr & 32'hFFFF_FFFC;
          store_q <= bus.ld_data;
          last_q  <= bus.ld_last;
          wcnt_q  <= '0;
        end
        LOAD_WR: if (rs != ACCESS) wcnt_q <= wcnt_inc[15:0];
        RUN: if (bus.halt) begin
          idx_q  <= '0;
          addr_q <= DUMP_BASE;
          wcnt_q <= '0;
        end
        DUMP_RD: begin
          if (rs != ACCESS) wcnt_q <= wcnt_inc[15:0];
          else begin
            dp_data_q <= bus.load;
            dp_addr_q <= addr_q;
          end
        end
        DUMP_OUT: if (bus.dp_ready && !last_word) begin
          idx_q  <= idx_q + 32'd1;
          addr_q <= DUMP_BASE + ((idx_q + 32'd1) << 2);
          wcnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_ready = ld_ready_c;
  assign bus.cpu_run  = cpu_run_c;
  assign bus.dp_valid = dp_valid_c;
  assign bus.dp_done  = dp_done_c;
  assign bus.err      = err_c;
  assign bus.tbCTRL   = tbctrl_c;
  assign bus.WEN      = wen_c;
  assign bus.REN      = ren_c;
  assign bus.addr     = addr_q;
  assign bus.store    = store_q;
  assign bus.dp_addr  = dp_addr_q;
  assign bus.dp_data  = dp_data_q;

endmodule

// File: tb/tb_ram_image_port.sv
// Directed bench for ram_image_port with a behavioural RAM: image load, address
// alignment, dump with backpressure, timeout, RAM error and reset mid-dump.
module tb_ram_image_port;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  ram_image_port_if bus ();

  ram_image_port #(
    .DUMP_BASE (32'h100),
    .DUMP_WORDS(4),
    .TIMEOUT   (8)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // RAM model: mode 0 = normal (LAT busy cycles then ACCESS), 1 = stuck BUSY, 2 = ERROR.
  localparam int LAT = 2;
  int          mode = 0;
  int          lat_cnt = 0;
  logic [31:0] mem [0:255];
  logic [1:0]  rs;

  always_comb begin
    rs = 2'd0;
    if (mode == 2) rs = 2'd3;
    else if (bus.WEN || bus.REN) rs = (mode == 0 && lat_cnt == LAT) ? 2'd2 : 2'd1;
  end
  assign bus.ramstate = rs;
  assign bus.load     = mem[bus.addr[9:2]];

  always @(posedge CLK) begin
    if ((bus.WEN || bus.REN) && rs != 2'd2) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
    if (bus.WEN && rs == 2'd2) mem[bus.addr[9:2]] <= bus.store;
  end

  task automatic apply_reset;
    nRST = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.halt = 1'b0; bus.dp_ready = 1'b0; mode = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  // Presents one word for a single cycle; returns on the negedge after the accept.
  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic l);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_data = d; bus.ld_last = l;
    @(negedge CLK);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic wait_wen_low(output int n);
    n = 0;
    while (bus.WEN === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    bus.ld_valid = 1'b0; bus.halt = 1'b0; bus.dp_ready = 1'b0; mode = 0;
    nRST = 1'b0;
    @(negedge CLK);
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%b exp=1", bus.ld_ready); end
    checks++; if (bus.tbCTRL !== 1'b1) begin errors++; $display("FAIL reset_tbCTRL got=%b exp=1", bus.tbCTRL); end
    checks++; if ({bus.cpu_run, bus.WEN, bus.REN, bus.dp_valid, bus.dp_done, bus.err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {bus.cpu_run, bus.WEN, bus.REN, bus.dp_valid, bus.dp_done, bus.err}); end
    checks++; if ({bus.addr, bus.store, bus.dp_addr, bus.dp_data} !== 128'h0) begin
      errors++; $display("FAIL reset_regs got=%h exp=0", {bus.addr, bus.store, bus.dp_addr, bus.dp_data}); end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_align_hold;
    int n, rdy_bad, addr_bad;
    apply_reset();
    bus.halt = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h13; bus.ld_data = 32'hCAFE_0013; bus.ld_last = 1'b0;
    @(negedge CLK);
    n = 0; rdy_bad = 0; addr_bad = 0;
    while (bus.WEN === 1'b1 && n < 40) begin
      if (bus.ld_ready !== 1'b0) rdy_bad++;
      if (bus.addr !== 32'h10) addr_bad++;
      n++;
      @(negedge CLK);
    end
    checks++; if (n != 3) begin errors++; $display("FAIL align_wen_cycles got=%0d exp=3", n); end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL hold_ld_ready_low got=%0d exp=0", rdy_bad); end
    checks++; if (addr_bad != 0) begin errors++; $display("FAIL align_addr got=%0d bad cycles exp=0", addr_bad); end
    checks++; if (mem[4] !== 32'hCAFE_0013) begin errors++; $display("FAIL align_mem got=%h exp=cafe0013", mem[4]); end
    checks++; if (bus.ld_ready !== 1'b1 || bus.cpu_run !== 1'b0) begin
      errors++; $display("FAIL halt_ignored got=%b%b exp=10", bus.ld_ready, bus.cpu_run); end
    bus.ld_valid = 1'b0; bus.halt = 1'b0;
    @(negedge CLK);
    checks++; if (bus.WEN !== 1'b0) begin errors++; $display("FAIL hold_no_second_accept got=%b exp=0", bus.WEN); end
  endtask

  task automatic test_load;
    logic [31:0] w [3];
    int n;
    w[0] = 32'h1111_2222; w[1] = 32'h3333_4444; w[2] = 32'hDEAD_BEEF;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send_word(32'(4 * i), w[i], i == 2);
      checks++; if (bus.WEN !== 1'b1 || bus.addr !== 32'(4 * i) || bus.store !== w[i]) begin
        errors++; $display("FAIL load_wr_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.WEN, bus.addr, bus.store, 32'(4 * i), w[i]); end
      wait_wen_low(n);
      checks++; if (n != 3) begin errors++; $display("FAIL load_wen_cycles_%0d got=%0d exp=3", i, n); end
      if (i < 2) begin
        checks++; if (bus.ld_ready !== 1'b1 || bus.cpu_run !== 1'b0) begin
          errors++; $display("FAIL load_back_idle_%0d got=%b%b exp=10", i, bus.ld_ready, bus.cpu_run); end
      end
    end
    checks++; if (bus.cpu_run !== 1'b1 || bus.tbCTRL !== 1'b0 || bus.ld_ready !== 1'b0) begin
      errors++; $display("FAIL load_run got=%b%b%b exp=100", bus.cpu_run, bus.tbCTRL, bus.ld_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[i] !== w[i]) begin errors++; $display("FAIL load_mem_%0d got=%h exp=%h", i, mem[i], w[i]); end
    end
  endtask

  task automatic test_dump;
    logic [31:0] w [4];
    int n, bad;
    w[0] = 32'hA0A0_0100; w[1] = 32'hB1B1_0104; w[2] = 32'hC2C2_0108; w[3] = 32'hD3D3_010C;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send_word(32'h100 + 32'(4 * i), w[i], i == 3);
      wait_wen_low(n);
    end
    checks++; if (bus.cpu_run !== 1'b1 || bus.tbCTRL !== 1'b0) begin
      errors++; $display("FAIL dump_pre_run got=%b%b exp=10", bus.cpu_run, bus.tbCTRL); end
    bus.halt = 1'b1;
    @(negedge CLK);
    checks++; if (bus.REN !== 1'b1 || bus.WEN !== 1'b0 || bus.tbCTRL !== 1'b1 || bus.addr !== 32'h100) begin
      errors++; $display("FAIL dump_first_rd got=%b%b%b/%h exp=101/00000100", bus.REN, bus.WEN, bus.tbCTRL, bus.addr); end
    bus.halt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus.dp_valid !== 1'b1 && n < 40) begin n++; @(negedge CLK); end
      checks++; if (bus.dp_valid !== 1'b1) begin errors++; $display("FAIL dump_valid_%0d got=%b exp=1", k, bus.dp_valid); end
      checks++; if (bus.dp_addr !== 32'h100 + 32'(4 * k) || bus.dp_data !== w[k]) begin
        errors++; $display("FAIL dump_word_%0d got=%h/%h exp=%h/%h", k, bus.dp_addr, bus.dp_data, 32'h100 + 32'(4 * k), w[k]); end
      if (k == 3) begin
        checks++; if (bus.dp_done !== 1'b0) begin errors++; $display("FAIL dump_done_early got=%b exp=0", bus.dp_done); end
      end
      if (k == 2) begin
        bad = 0;
        repeat (5) begin
          @(negedge CLK);
          if (bus.dp_valid !== 1'b1 || bus.dp_addr !== 32'h108 || bus.dp_data !== w[2] || bus.REN !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL dump_stall_stable got=%0d bad cycles exp=0", bad); end
      end
      bus.dp_ready = 1'b1;
      @(negedge CLK);
      bus.dp_ready = 1'b0;
    end
    checks++; if (bus.dp_done !== 1'b1 || bus.dp_valid !== 1'b0 || bus.REN !== 1'b0) begin
      errors++; $display("FAIL dump_done got=%b%b%b exp=100", bus.dp_done, bus.dp_valid, bus.REN); end
    repeat (3) @(negedge CLK);
    checks++; if (bus.dp_done !== 1'b1 || bus.tbCTRL !== 1'b1 || bus.cpu_run !== 1'b1 || bus.REN !== 1'b0) begin
      errors++; $display("FAIL done_sticky got=%b%b%b%b exp=1110", bus.dp_done, bus.tbCTRL, bus.cpu_run, bus.REN); end
  endtask

  task automatic test_timeout;
    int n, bad;
    apply_reset();
    mode = 1;
    send_word(32'h20, 32'h55, 1'b1);
    wait_wen_low(n);
    checks++; if (n != 8) begin errors++; $display("FAIL timeout_wait_cycles got=%0d exp=8", n); end
    checks++; if (bus.err !== 1'b1 || bus.WEN !== 1'b0 || bus.cpu_run !== 1'b0 || bus.ld_ready !== 1'b0 || bus.tbCTRL !== 1'b1) begin
      errors++; $display("FAIL timeout_fault got=%b%b%b%b%b exp=10001", bus.err, bus.WEN, bus.cpu_run, bus.ld_ready, bus.tbCTRL); end
    bus.ld_valid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.err !== 1'b1 || bus.ld_ready !== 1'b0 || bus.WEN !== 1'b0) bad++;
    end
    bus.ld_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL fault_terminal got=%0d bad cycles exp=0", bad); end
    mode = 0;
  endtask

  task automatic test_dump_error;
    int n;
    apply_reset();
    send_word(32'h100, 32'h77, 1'b1);
    wait_wen_low(n);
    bus.halt = 1'b1;
    @(negedge CLK);
    checks++; if (bus.REN !== 1'b1) begin errors++; $display("FAIL err_pre_ren got=%b exp=1", bus.REN); end
    mode = 2;
    @(negedge CLK);
    checks++; if (bus.err !== 1'b1 || bus.dp_done !== 1'b0 || bus.dp_valid !== 1'b0 || bus.REN !== 1'b0 || bus.cpu_run !== 1'b0) begin
      errors++; $display("FAIL dump_error got=%b%b%b%b%b exp=10000", bus.err, bus.dp_done, bus.dp_valid, bus.REN, bus.cpu_run); end
    mode = 0; bus.halt = 1'b0;
  endtask

  task automatic test_reset_mid_dump;
    int n;
    apply_reset();
    send_word(32'h100, 32'h9ABC_DEF0, 1'b1);
    wait_wen_low(n);
    bus.halt = 1'b1;
    n = 0;
    while (bus.dp_valid !== 1'b1 && n < 40) begin n++; @(negedge CLK); end
    checks++; if (bus.dp_valid !== 1'b1 || bus.dp_data !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL rst_pre_dump got=%b/%h exp=1/9abcdef0", bus.dp_valid, bus.dp_data); end
    bus.halt = 1'b0;
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    checks++; if (bus.dp_valid !== 1'b0 || bus.dp_addr !== 32'h0 || bus.dp_data !== 32'h0 || bus.addr !== 32'h0) begin
      errors++; $display("FAIL rst_async_dp got=%b/%h/%h/%h exp=0/0/0/0", bus.dp_valid, bus.dp_addr, bus.dp_data, bus.addr); end
    checks++; if (bus.cpu_run !== 1'b0 || bus.tbCTRL !== 1'b1 || bus.ld_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async_ctrl got=%b%b%b exp=011", bus.cpu_run, bus.tbCTRL, bus.ld_ready); end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.ld_ready !== 1'b1 || bus.WEN !== 1'b0 || bus.REN !== 1'b0 || bus.err !== 1'b0 || bus.dp_done !== 1'b0) begin
      errors++; $display("FAIL rst_release got=%b%b%b%b%b exp=10000", bus.ld_ready, bus.WEN, bus.REN, bus.err, bus.dp_done); end
  endtask

  initial begin
    test_reset();
    test_align_hold();
    test_load();
    test_dump();
    test_timeout();
    test_dump_error();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
